// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with one bidirectional data bus.
// Ports: clk, rst (sync, active-high), addr, data (inout), cs, we, oe.
module single_port_sync_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drv_en;

  // Reset blocks writes; memory itself is never cleared.
  assign wr_en  = !rst && cs && we;
  assign rd_en  = cs && !we;
  assign drv_en = cs && !we && oe;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[addr];
    end
  end

  assign data = drv_en ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Directed bench for single_port_sync_ram.
// Read results flow through a scoreboard queue.
module tb_single_port_sync_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic        cs;
  logic        we;
  logic        oe;
  logic [7:0]  drv;
  logic        drv_en;
  wire  [7:0]  data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] model [int];

  assign data = drv_en ? drv : 8'bz;

  always #5 clk = ~clk;

  single_port_sync_ram #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .addr(addr),
    .data(data),
    .cs  (cs),
    .we  (we),
    .oe  (oe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    cs     = 1'b1;
    we     = 1'b1;
    oe     = 1'b0;
    addr   = a;
    drv    = d;
    drv_en = 1'b1;
    tick();
    model[int'(a)] = d;
    drv_en = 1'b0;
    cs     = 1'b0;
    we     = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input string tag);
    logic [7:0] e;
    cs     = 1'b1;
    we     = 1'b0;
    oe     = 1'b1;
    drv_en = 1'b0;
    addr   = a;
    exp_q.push_back(model[int'(a)]);
    tick();
    e = exp_q.pop_front();
    chk(tag, data, e);
  endtask

  logic [7:0] pat [16];

  initial begin
    pat = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12,
            8'h01, 8'h76, 8'h3D, 8'hED, 8'h8C, 8'hF9, 8'hC6, 8'hC5};
    rst    = 1'b1;
    cs     = 1'b0;
    we     = 1'b0;
    oe     = 1'b0;
    addr   = '0;
    drv    = '0;
    drv_en = 1'b0;

    // reset, then read-enable the bus without a clock edge
    tick();
    tick();
    rst = 1'b0;
    cs  = 1'b1;
    we  = 1'b0;
    oe  = 1'b1;
    #1;
    chk("reset_bus_zero", data, 8'h00);
    cs = 1'b0;
    oe = 1'b0;

    // sequential write then read
    for (int i = 0; i < 16; i++) begin
      wr(12'(i), pat[i]);
    end
    for (int i = 0; i < 16; i++) begin
      rd(12'(i), $sformatf("seq_rd_%0d", i));
    end

    // read on the edge right after the write
    wr(12'h7FF, 8'hA5);
    rd(12'h7FF, "raw_same_addr");

    // tristate control, no clock edge in between
    oe     = 1'b0;
    drv    = 8'h05;
    drv_en = 1'b1;
    #1;
    chk("tri_oe_low", data, 8'h05);
    cs = 1'b0;
    oe = 1'b1;
    #1;
    chk("tri_cs_low", data, 8'h05);
    cs = 1'b1;
    we = 1'b1;
    #1;
    chk("tri_we_high", data, 8'h05);
    we     = 1'b0;
    drv_en = 1'b0;
    #1;
    chk("tri_reenable", data, 8'hA5);
    cs = 1'b0;

    // chip select blocks writes
    wr(12'h003, 8'h12);
    cs     = 1'b0;
    we     = 1'b1;
    oe     = 1'b0;
    addr   = 12'h003;
    drv    = 8'hFF;
    drv_en = 1'b1;
    tick();
    drv_en = 1'b0;
    we     = 1'b0;
    rd(12'h005, "cs_gate_other");
    rd(12'h003, "cs_gate_hold");

    // reset mid-operation
    wr(12'h005, 8'h3C);
    rd(12'h005, "pre_reset_rd");
    rst    = 1'b1;
    cs     = 1'b1;
    we     = 1'b1;
    oe     = 1'b0;
    addr   = 12'h005;
    drv    = 8'h99;
    drv_en = 1'b1;
    tick();
    rst    = 1'b0;
    drv_en = 1'b0;
    we     = 1'b0;
    oe     = 1'b1;
    #1;
    chk("mid_reset_zero", data, 8'h00);
    rd(12'h005, "post_reset_retain");
    rd(12'h7FF, "post_reset_top");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0",
             exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
